// File: rtl/timekeeper_pkg.sv
// ============================================================================
// timekeeper_pkg : segment glyphs and BCD validity helpers for the timekeeper
// Revision 1.0
// ============================================================================
`default_nettype none

package timekeeper_pkg;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG7_0    = 7'h40;
  localparam logic [6:0] SEG7_1    = 7'h79;
  localparam logic [6:0] SEG7_2    = 7'h24;
  localparam logic [6:0] SEG7_3    = 7'h30;
  localparam logic [6:0] SEG7_4    = 7'h19;
  localparam logic [6:0] SEG7_5    = 7'h12;
  localparam logic [6:0] SEG7_6    = 7'h02;
  localparam logic [6:0] SEG7_7    = 7'h78;
  localparam logic [6:0] SEG7_8    = 7'h00;
  localparam logic [6:0] SEG7_9    = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [7:0] PAIR_MAX  = 8'h59;

  // BCD ordering matches unsigned ordering once both nibbles are decimal
  function automatic logic bcd_pair_valid(input logic [7:0] pair, input logic [7:0] max);
    return (pair[3:0] <= 4'd9) && (pair[7:4] <= 4'd9) && (pair <= max);
  endfunction

  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = SEG7_0;
      4'd1:    glyph = SEG7_1;
      4'd2:    glyph = SEG7_2;
      4'd3:    glyph = SEG7_3;
      4'd4:    glyph = SEG7_4;
      4'd5:    glyph = SEG7_5;
      4'd6:    glyph = SEG7_6;
      4'd7:    glyph = SEG7_7;
      4'd8:    glyph = SEG7_8;
      4'd9:    glyph = SEG7_9;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_pair_counter.sv
// ============================================================================
// bcd_pair_counter : two-digit BCD counter with load, programmable wrap, carry
// Revision 1.0
// ============================================================================
`default_nettype none

module bcd_pair_counter
  import timekeeper_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] d_i,
  input  logic [7:0] max_i,
  output logic [7:0] q_o,
  output logic [7:0] nxt_o,
  output logic       carry_o
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = d_i;
    end else if (inc_i) begin
      if (q_q == max_i) begin
        q_d = 8'h00;
      end else if (q_q[3:0] == 4'd9) begin
        q_d = {q_q[7:4] + 4'd1, 4'd0};
      end else begin
        q_d = {q_q[7:4], q_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 8'h00;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o     = q_q;
  assign nxt_o   = q_d;
  assign carry_o = inc_i && (q_q == max_i);

endmodule

`default_nettype wire

// File: rtl/bcd_timekeeper_display.sv
// ============================================================================
// bcd_timekeeper_display : BCD time-of-day counter with 7-segment scan driver
// Optional alarm compare/blink enabled by defining ALARM_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module bcd_timekeeper_display
  import timekeeper_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned SCAN_DIV   = 100_000,
  parameter logic [7:0]  TOP_MAX    = 8'h59
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic                    load_err,
  output logic [4*NUM_DIGITS-1:0] time_out,
  output logic                    tick,
  input  logic                    alarm_set,
  input  logic                    alarm_ack,
  output logic                    alarm_active,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg
);

  localparam int TW        = 4 * NUM_DIGITS;
  localparam int NUM_PAIRS = NUM_DIGITS / 2;
  localparam int PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W     = $clog2(NUM_DIGITS);

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic                  tick_q;
  logic                  load_err_q, load_err_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;
  logic                  active_q;

  logic                  w_load_valid;
  logic                  w_load_ok;
  logic                  w_pre_wrap;
  logic                  w_adv;
  logic                  w_scan_wrap;
  logic [3:0]            w_digit;
  logic [NUM_PAIRS-1:0]  w_inc;
  logic [NUM_PAIRS-1:0]  w_carry;
  logic [TW-1:0]         w_time_nxt;

  // Same rule guards both time load and alarm set
  always_comb begin
    w_load_valid = 1'b1;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (!bcd_pair_valid(load_val[8*p +: 8], (p == NUM_PAIRS-1) ? TOP_MAX : PAIR_MAX)) begin
        w_load_valid = 1'b0;
      end
    end
  end

  assign w_load_ok  = load && w_load_valid;
  assign w_pre_wrap = (pre_q == PRE_W'(TICK_DIV - 1));
  assign w_adv      = w_pre_wrap && !w_load_ok;
  assign w_inc[0]   = w_adv;

  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
    localparam logic [7:0] P_MAX = (p == NUM_PAIRS-1) ? TOP_MAX : PAIR_MAX;
    if (p > 0) begin : g_chain
      assign w_inc[p] = w_carry[p-1];
    end
    bcd_pair_counter u_pair (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (w_inc[p]),
      .load_i  (w_load_ok),
      .d_i     (load_val[8*p +: 8]),
      .max_i   (P_MAX),
      .q_o     (time_out[8*p +: 8]),
      .nxt_o   (w_time_nxt[8*p +: 8]),
      .carry_o (w_carry[p])
    );
  end

  assign w_scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));
  assign w_digit     = 4'(time_out >> {idx_q, 2'b00});

  always_comb begin
    pre_d = pre_q + 1'b1;
    if (w_load_ok || w_pre_wrap) begin
      pre_d = '0;
    end

    load_err_d = load && !w_load_valid;
`ifdef ALARM_EN
    if (alarm_set && !w_load_valid) begin
      load_err_d = 1'b1;
    end
`endif

    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (w_scan_wrap) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    // Display registers lag the scan index by one cycle
    anode_d = ~(NUM_DIGITS'(1) << idx_q);
    seg_d   = seg7_decode(w_digit);
    if (active_q && !pre_q[PRE_W-1]) begin
      seg_d = 7'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q      <= '0;
      tick_q     <= 1'b0;
      load_err_q <= 1'b0;
      scan_q     <= '0;
      idx_q      <= '0;
      anode_q    <= '1;
      seg_q      <= SEG_BLANK;
    end else begin
      pre_q      <= pre_d;
      tick_q     <= w_adv;
      load_err_q <= load_err_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
    end
  end

`ifdef ALARM_EN
  logic [TW-1:0] alarm_q;
  logic          w_match;
  logic          w_unused_top_carry;

  assign w_unused_top_carry = w_carry[NUM_PAIRS-1];
  assign w_match            = w_adv && (w_time_nxt == alarm_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_q  <= '0;
      active_q <= 1'b0;
    end else begin
      if (alarm_set && w_load_valid) begin
        alarm_q <= load_val;
      end
      if (w_match) begin
        active_q <= 1'b1;
      end else if (alarm_ack) begin
        active_q <= 1'b0;
      end
    end
  end
`else
  logic w_unused_alarm;

  assign w_unused_alarm = ^{alarm_set, alarm_ack, w_time_nxt, w_carry[NUM_PAIRS-1]};
  assign active_q       = 1'b0;
`endif

  assign tick         = tick_q;
  assign load_err     = load_err_q;
  assign anode        = anode_q;
  assign seg          = seg_q;
  assign alarm_active = active_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_timekeeper_display.sv
// ============================================================================
// tb_bcd_timekeeper_display : directed stimulus, seconds-based reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_bcd_timekeeper_display;

  localparam int ND = 4;
  localparam int TD = 4;
  localparam int SD = 2;
`ifdef ALARM_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, load, alarm_set, alarm_ack;
  logic [15:0] load_val;
  logic        load_err, tick, alarm_active;
  logic [15:0] time_out;
  logic [3:0]  anode;
  logic [6:0]  seg;

  bcd_timekeeper_display #(
    .NUM_DIGITS (ND),
    .TICK_DIV   (TD),
    .SCAN_DIV   (SD),
    .TOP_MAX    (8'h59)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .load_val     (load_val),
    .load_err     (load_err),
    .time_out     (time_out),
    .tick         (tick),
    .alarm_set    (alarm_set),
    .alarm_ack    (alarm_ack),
    .alarm_active (alarm_active),
    .anode        (anode),
    .seg          (seg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // -1 when the value is not a legal MM:SS
  function automatic int bcd_to_sec(input logic [15:0] v);
    int d0, d1, d2, d3;
    d0 = int'(v[3:0]);
    d1 = int'(v[7:4]);
    d2 = int'(v[11:8]);
    d3 = int'(v[15:12]);
    if (d0 > 9 || d1 > 5 || d2 > 9 || d3 > 5) return -1;
    return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
  endfunction

  function automatic logic [15:0] sec_to_bcd(input int s);
    int mm, ss;
    logic [15:0] r;
    mm = s / 60;
    ss = s % 60;
    r[15:12] = 4'(mm / 10);
    r[11:8]  = 4'(mm % 10);
    r[7:4]   = 4'(ss / 10);
    r[3:0]   = 4'(ss % 10);
    return r;
  endfunction

  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int         m_sec, m_pre, m_scan, m_idx, m_alarm;
  bit         m_tick, m_err, m_active, m_ok;
  logic [3:0] m_anode;
  logic [6:0] m_seg;

  initial m_ok = 1'b0;

  always @(posedge clk) begin
    int v;
    int dig;
    logic [15:0] cur;
    v = bcd_to_sec(load_val);
    if (reset) begin
      m_ok = 1'b1; m_sec = 0; m_pre = 0; m_scan = 0; m_idx = 0; m_alarm = 0;
      m_tick = 1'b0; m_err = 1'b0; m_active = 1'b0; m_anode = 4'hF; m_seg = 7'h7F;
    end else if (m_ok) begin
      cur     = sec_to_bcd(m_sec);
      dig     = int'((cur >> (4 * m_idx)) & 16'hF);
      m_anode = ~(4'b0001 << m_idx);
      m_seg   = glyph[dig];
      if (m_active && m_pre < TD / 2) m_seg = 7'h00;
      if (m_scan == SD - 1) begin
        m_scan = 0;
        m_idx  = (m_idx + 1) % ND;
      end else begin
        m_scan++;
      end
      m_err  = load && (v < 0);
      m_tick = 1'b0;
      if (load && v >= 0) begin
        m_sec = v;
        m_pre = 0;
      end else if (m_pre == TD - 1) begin
        m_pre  = 0;
        m_sec  = (m_sec + 1) % 3600;
        m_tick = 1'b1;
      end else begin
        m_pre++;
      end
`ifdef ALARM_EN
      if (alarm_set && v < 0) m_err = 1'b1;
      if (m_tick && m_sec == m_alarm) m_active = 1'b1;
      else if (alarm_ack) m_active = 1'b0;
      if (alarm_set && v >= 0) m_alarm = v;
`endif
    end
    #1;
    if (m_ok) begin
      chk("m_time",   time_out,     sec_to_bcd(m_sec));
      chk("m_tick",   tick,         m_tick);
      chk("m_err",    load_err,     m_err);
      chk("m_anode",  anode,        m_anode);
      chk("m_seg",    seg,          m_seg);
      chk("m_alarm",  alarm_active, m_active);
    end
  end

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 20);
  endtask

  logic [3:0] an_exp [8] = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};

  initial begin
    int n;
    reset = 1'b1; load = 1'b0; load_val = '0; alarm_set = 1'b0; alarm_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_time",  time_out, 16'h0000);
    chk("rst_anode", anode,    4'hF);
    chk("rst_seg",   seg,      7'h7F);
    chk("rst_tick",  tick,     1'b0);

    wait_tick(n);
    chk("first_tick_lat",  n,        4);
    chk("first_tick_time", time_out, 16'h0001);

    load = 1'b1; load_val = 16'h5958;
    @(negedge clk);
    load = 1'b0;
    chk("load_5958", time_out, 16'h5958);
    wait_tick(n);
    chk("tick_gap_a", n,        4);
    chk("time_5959",  time_out, 16'h5959);
    wait_tick(n);
    chk("tick_gap_b", n,        4);
    chk("full_wrap",  time_out, 16'h0000);

    load = 1'b1; load_val = 16'h0969;
    @(negedge clk);
    load = 1'b0;
    chk("err_0969",      load_err, 1'b1);
    chk("err_0969_time", time_out, 16'h0000);
    @(negedge clk);
    chk("err_pulse_end", load_err, 1'b0);
    load = 1'b1; load_val = 16'h6000;
    @(negedge clk);
    load = 1'b0;
    chk("err_6000",      load_err, 1'b1);
    chk("err_6000_time", time_out, 16'h0000);

    wait_tick(n);
    repeat (3) @(negedge clk);
    load = 1'b1; load_val = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    chk("load_beats_tick", time_out, 16'h1234);
    chk("no_tick_on_load", tick,     1'b0);
    wait_tick(n);
    chk("after_load_lat", n,        4);
    chk("time_1235",      time_out, 16'h1235);

    alarm_set = 1'b1; load_val = 16'h0005;
    @(negedge clk);
    alarm_set = 1'b0;
    load = 1'b1; load_val = 16'h0003;
    @(negedge clk);
    load = 1'b0;
    wait_tick(n);
    chk("alarm_pre",  alarm_active, 1'b0);
    chk("time_0004",  time_out,     16'h0004);
    wait_tick(n);
    chk("alarm_hit",  alarm_active, ALM);
    chk("time_0005",  time_out,     16'h0005);
    repeat (2) @(negedge clk);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    chk("alarm_ack",  alarm_active, 1'b0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("scan_anode", anode, an_exp[i]);
      chk("scan_seg",   seg,   7'h40);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
